// File: rtl/cabac_range_update4_if.sv
// Group-level bus between the rLPS lookup stage, the range update stage and
// the low/bit-output stage of the 4-bin CABAC encoder pipeline.
//   control  : enable (advance), en (0 = flush), init (slice start)
//   group    : number_range, number_all, index_bypass, symbol_bypass
//   per bin k: in_lpsmps_k, in_four_rlps_k, in_four_rlps_shift_k
//   results  : out_number_range, out_number_all, out_index_bypass,
//              out_symbol_bypass, out_bin_valid, out_low_add_k, out_shift_k,
//              out_range
interface cabac_range_update4_if;
  logic        enable;
  logic        en;
  logic        init;
  logic [2:0]  number_range;
  logic [3:0]  number_all;
  logic [7:0]  index_bypass;
  logic [7:0]  symbol_bypass;
  logic        in_lpsmps_0;
  logic        in_lpsmps_1;
  logic        in_lpsmps_2;
  logic        in_lpsmps_3;
  logic [31:0] in_four_rlps_0;
  logic [31:0] in_four_rlps_1;
  logic [31:0] in_four_rlps_2;
  logic [31:0] in_four_rlps_3;
  logic [43:0] in_four_rlps_shift_0;
  logic [43:0] in_four_rlps_shift_1;
  logic [43:0] in_four_rlps_shift_2;
  logic [43:0] in_four_rlps_shift_3;

  logic [2:0]  out_number_range;
  logic [3:0]  out_number_all;
  logic [7:0]  out_index_bypass;
  logic [7:0]  out_symbol_bypass;
  logic [3:0]  out_bin_valid;
  logic [8:0]  out_low_add_0;
  logic [8:0]  out_low_add_1;
  logic [8:0]  out_low_add_2;
  logic [8:0]  out_low_add_3;
  logic [2:0]  out_shift_0;
  logic [2:0]  out_shift_1;
  logic [2:0]  out_shift_2;
  logic [2:0]  out_shift_3;
  logic [8:0]  out_range;

  // Upstream/testbench side: drives the group, observes the results.
  modport master (
    output enable, en, init, number_range, number_all, index_bypass, symbol_bypass,
           in_lpsmps_0, in_lpsmps_1, in_lpsmps_2, in_lpsmps_3,
           in_four_rlps_0, in_four_rlps_1, in_four_rlps_2, in_four_rlps_3,
           in_four_rlps_shift_0, in_four_rlps_shift_1,
           in_four_rlps_shift_2, in_four_rlps_shift_3,
    input  out_number_range, out_number_all, out_index_bypass, out_symbol_bypass,
           out_bin_valid, out_low_add_0, out_low_add_1, out_low_add_2, out_low_add_3,
           out_shift_0, out_shift_1, out_shift_2, out_shift_3, out_range
  );

  // Range update stage side.
  modport slave (
    input  enable, en, init, number_range, number_all, index_bypass, symbol_bypass,
           in_lpsmps_0, in_lpsmps_1, in_lpsmps_2, in_lpsmps_3,
           in_four_rlps_0, in_four_rlps_1, in_four_rlps_2, in_four_rlps_3,
           in_four_rlps_shift_0, in_four_rlps_shift_1,
           in_four_rlps_shift_2, in_four_rlps_shift_3,
    output out_number_range, out_number_all, out_index_bypass, out_symbol_bypass,
           out_bin_valid, out_low_add_0, out_low_add_1, out_low_add_2, out_low_add_3,
           out_shift_0, out_shift_1, out_shift_2, out_shift_3, out_range
  );
endinterface

// File: rtl/cabac_range_update4.sv
// CABAC 4-bin range update stage. Owns the 9-bit coding range register and
// resolves up to four regular bins per cycle as a serial combinational chain,
// registering per-bin low-update words (add value, shift count). Bypass
// bookkeeping is passed through one cycle delayed.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (range := RANGE_INIT, rest := 0)
//   bus    cabac_range_update4_if.slave (group inputs and registered results)
module cabac_range_update4 #(
  parameter logic [8:0] RANGE_INIT = 9'd510
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cabac_range_update4_if.slave        bus
);

  localparam int unsigned NBINS   = 4;
  localparam int unsigned RANGE_W = 9;
  localparam int unsigned SHIFT_W = 3;

  // Output registers
  logic [RANGE_W-1:0] r_range;
  logic [2:0]         r_number_range;
  logic [3:0]         r_number_all;
  logic [7:0]         r_index_bypass;
  logic [7:0]         r_symbol_bypass;
  logic [NBINS-1:0]   r_bin_valid;
  logic [RANGE_W-1:0] r_low_add [NBINS];
  logic [SHIFT_W-1:0] r_shift   [NBINS];

  // Chain wires
  logic [NBINS-1:0]   w_lps;
  logic [31:0]        w_rlps_tab  [NBINS];
  logic [43:0]        w_shift_tab [NBINS];
  logic [2:0]         w_nvalid;
  logic [RANGE_W-1:0] w_r       [NBINS+1];
  logic [7:0]         w_rlps    [NBINS];
  logic [10:0]        w_field   [NBINS];
  logic [RANGE_W-1:0] w_m       [NBINS];
  logic [NBINS-1:0]   w_valid;
  logic [RANGE_W-1:0] w_low_add [NBINS];
  logic [SHIFT_W-1:0] w_shift   [NBINS];

  // rLPS byte for qIdx q (q0 in the top byte).
  function automatic logic [7:0] sel_rlps(input logic [31:0] t, input logic [1:0] q);
    logic [7:0] v;
    unique case (q)
      2'd0:    v = t[31:24];
      2'd1:    v = t[23:16];
      2'd2:    v = t[15:8];
      default: v = t[7:0];
    endcase
    return v;
  endfunction

  // Pre-renormalized LPS entry {shift, rng} for qIdx q (q0 at the top).
  function automatic logic [10:0] sel_field(input logic [43:0] t, input logic [1:0] q);
    logic [10:0] v;
    unique case (q)
      2'd0:    v = t[43:33];
      2'd1:    v = t[32:22];
      2'd2:    v = t[21:11];
      default: v = t[10:0];
    endcase
    return v;
  endfunction

  assign w_lps = {bus.in_lpsmps_3, bus.in_lpsmps_2, bus.in_lpsmps_1, bus.in_lpsmps_0};

  assign w_rlps_tab[0]  = bus.in_four_rlps_0;
  assign w_rlps_tab[1]  = bus.in_four_rlps_1;
  assign w_rlps_tab[2]  = bus.in_four_rlps_2;
  assign w_rlps_tab[3]  = bus.in_four_rlps_3;
  assign w_shift_tab[0] = bus.in_four_rlps_shift_0;
  assign w_shift_tab[1] = bus.in_four_rlps_shift_1;
  assign w_shift_tab[2] = bus.in_four_rlps_shift_2;
  assign w_shift_tab[3] = bus.in_four_rlps_shift_3;

  // Serial 4-bin range chain; init substitutes RANGE_INIT at the head so a
  // slice start and the first bin group can share a cycle.
  always_comb begin
    w_nvalid = (bus.number_range > 3'd4) ? 3'd4 : bus.number_range;
    w_r[0]   = bus.init ? RANGE_INIT : r_range;
    w_valid  = '0;
    for (int k = 0; k < NBINS; k++) begin
      w_low_add[k] = '0;
      w_shift[k]   = '0;
      w_rlps[k]    = sel_rlps(w_rlps_tab[k], w_r[k][7:6]);
      w_field[k]   = sel_field(w_shift_tab[k], w_r[k][7:6]);
      w_m[k]       = w_r[k] - {1'b0, w_rlps[k]};
      w_r[k+1]     = w_r[k];
      if (3'(k) < w_nvalid) begin
        w_valid[k] = 1'b1;
        if (w_lps[k]) begin
          w_low_add[k] = w_m[k];
          w_shift[k]   = w_field[k][10:8];
          w_r[k+1]     = {1'b1, w_field[k][7:0]};
        end else if (w_m[k][8]) begin
          w_r[k+1]     = w_m[k];
        end else begin
          // MPS dropped below 256: one-bit renormalization.
          w_shift[k]   = 3'd1;
          w_r[k+1]     = {w_m[k][7:0], 1'b0};
        end
      end
    end
  end

  // Range register and output registers: reset, then flush, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_range         <= RANGE_INIT;
      r_number_range  <= '0;
      r_number_all    <= '0;
      r_index_bypass  <= '0;
      r_symbol_bypass <= '0;
      r_bin_valid     <= '0;
      for (int k = 0; k < NBINS; k++) begin
        r_low_add[k] <= '0;
        r_shift[k]   <= '0;
      end
    end else if (!bus.en) begin
      if (bus.init) r_range <= RANGE_INIT;
      r_number_range  <= '0;
      r_number_all    <= '0;
      r_index_bypass  <= '0;
      r_symbol_bypass <= '0;
      r_bin_valid     <= '0;
      for (int k = 0; k < NBINS; k++) begin
        r_low_add[k] <= '0;
        r_shift[k]   <= '0;
      end
    end else if (bus.enable) begin
      r_range         <= w_r[NBINS];
      r_number_range  <= bus.number_range;
      r_number_all    <= bus.number_all;
      r_index_bypass  <= bus.index_bypass;
      r_symbol_bypass <= bus.symbol_bypass;
      r_bin_valid     <= w_valid;
      for (int k = 0; k < NBINS; k++) begin
        r_low_add[k] <= w_low_add[k];
        r_shift[k]   <= w_shift[k];
      end
    end else if (bus.init) begin
      // Stalled slice start still reloads the range.
      r_range <= RANGE_INIT;
    end
  end

  assign bus.out_range         = r_range;
  assign bus.out_number_range  = r_number_range;
  assign bus.out_number_all    = r_number_all;
  assign bus.out_index_bypass  = r_index_bypass;
  assign bus.out_symbol_bypass = r_symbol_bypass;
  assign bus.out_bin_valid     = r_bin_valid;
  assign bus.out_low_add_0     = r_low_add[0];
  assign bus.out_low_add_1     = r_low_add[1];
  assign bus.out_low_add_2     = r_low_add[2];
  assign bus.out_low_add_3     = r_low_add[3];
  assign bus.out_shift_0       = r_shift[0];
  assign bus.out_shift_1       = r_shift[1];
  assign bus.out_shift_2       = r_shift[2];
  assign bus.out_shift_3       = r_shift[3];

endmodule
